buzzer_tone_sched: RTL and testbench

Scheduler that shares one PWM buzzer between NUM_REQ requesters: a key-click beeper, an alarm and a melody player.
- Arbitrates pending tone requests by fixed priority.
- Drives the period, duty and enable configuration of the downstream buzzer PWM.
- Times each tone in milliseconds and inserts a silent gap between consecutive tones.
- Sits between the application FSMs and the buzzer PWM in the buzzer test designs.

---
 rtl/buzzer_pkg.sv | 22 ++
 rtl/buzzer_tone_sched_ms_tick_gen.sv | 47 ++++
 rtl/buzzer_tone_sched.sv | 172 +++++++++++++++++
 tb/tb_buzzer_tone_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the buzzer tone scheduler: FSM state encoding,
// the ms prescaler divisor and the fixed-priority one-hot picker.
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_e;

   localparam int MAX_REQ = 32;

   function automatic int ms_div(input int clk_freq);
      return clk_freq / 1000;
   endfunction

   // Isolates the lowest set bit, so index 0 always wins.
   function automatic logic [MAX_REQ-1:0] prio_pick(input logic [MAX_REQ-1:0] v);
      return v & (~v + 32'd1);
   endfunction

endpackage

// File: rtl/buzzer_tone_sched_ms_tick_gen.sv
// Millisecond prescaler: restart forces the count to zero; tick is a registered
// one-cycle pulse that is high in the last cycle of every ms.
module ms_tick_gen
   import buzzer_pkg::*;
#(
   parameter int MS_CYC = 50_000,
   parameter int PRE_W  = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [PRE_W-1:0] CNT_LAST = PRE_W'(MS_CYC - 1);

   logic [PRE_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Next count and look-ahead tick so tick_q tracks cnt_q == CNT_LAST.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + PRE_W'(1);
      end
      tick_d = (cnt_d == CNT_LAST);
   end

   // Prescaler registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/buzzer_tone_sched.sv
// Fixed-priority scheduler sharing one PWM buzzer between NUM_REQ requesters.
// Optional BUZZER_TONE_PREEMPT_EN lets a higher-priority request abort a tone.
module buzzer_tone_sched
   import buzzer_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int NUM_REQ  = 3,
   parameter int PERIOD_W = 24,
   parameter int DUR_W    = 16,
   parameter int GAP_MS   = 20
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*PERIOD_W-1:0]  req_period,
   input  logic [NUM_REQ*DUR_W-1:0]     req_dur_ms,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           done,
   output logic                         busy,
   output logic [PERIOD_W-1:0]          pwm_period,
   output logic [PERIOD_W-1:0]          pwm_duty,
   output logic                         pwm_en
);

   localparam int MS_CYC = ms_div(CLK_FREQ);
   localparam int PRE_W  = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
   localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 pwm_en_q, pwm_en_d;
   logic [PERIOD_W-1:0]  period_q, period_d;
   logic [PERIOD_W-1:0]  duty_q, duty_d;
   logic [DUR_W-1:0]     dur_q, dur_d;
   logic [DUR_W-1:0]     ms_cnt_q, ms_cnt_d;

   logic                 tick_s;
   logic                 restart_s;
   logic                 preempt_s;
   logic                 tone_end_s;
   logic [NUM_REQ-1:0]   pick_s;
   logic [PERIOD_W-1:0]  sel_period_s;
   logic [DUR_W-1:0]     sel_dur_s;

   ms_tick_gen #(
      .MS_CYC (MS_CYC),
      .PRE_W  (PRE_W)
   ) u_ms_tick_gen (
      .clk     (clk),
      .rst     (rst),
      .restart (restart_s),
      .tick    (tick_s)
   );

   // Arbitration winner and its tone parameters (pick_s is one-hot or zero).
   always_comb begin
      pick_s       = NUM_REQ'(prio_pick(MAX_REQ'(req)));
      sel_period_s = '0;
      sel_dur_s    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_period_s = sel_period_s | ({PERIOD_W{pick_s[i]}} & req_period[i*PERIOD_W +: PERIOD_W]);
         sel_dur_s    = sel_dur_s    | ({DUR_W{pick_s[i]}}    & req_dur_ms[i*DUR_W +: DUR_W]);
      end
`ifdef BUZZER_TONE_PREEMPT_EN
      // grant_q - 1 sets every bit below the granted index.
      preempt_s = |(req & (grant_q - NUM_REQ'(1)));
`else
      preempt_s = 1'b0;
`endif
      tone_end_s = (dur_q == '0) || (tick_s && ((ms_cnt_q + DUR_W'(1)) == dur_q));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      done_d    = '0;
      pwm_en_d  = pwm_en_q;
      period_d  = period_q;
      duty_d    = duty_q;
      dur_d     = dur_q;
      ms_cnt_d  = ms_cnt_q;
      restart_s = 1'b0;
      case (state_q)
         IDLE: begin
            restart_s = 1'b1;
            ms_cnt_d  = '0;
            if ((req != '0) && (done_q == '0)) begin
               state_d  = PLAY;
               grant_d  = pick_s;
               dur_d    = sel_dur_s;
               period_d = sel_period_s;
               duty_d   = sel_period_s >> 1;
               pwm_en_d = (sel_period_s != '0) && (sel_dur_s != '0);
            end else begin
               state_d = IDLE;
            end
         end
         PLAY: begin
            if (tone_end_s || preempt_s) begin
               // Natural completion wins over an abort arriving in the same cycle.
               state_d   = (tone_end_s && (GAP_MS > 0)) ? GAP : IDLE;
               grant_d   = '0;
               done_d    = grant_q;
               pwm_en_d  = 1'b0;
               period_d  = '0;
               duty_d    = '0;
               ms_cnt_d  = '0;
               restart_s = 1'b1;
            end else if (tick_s) begin
               ms_cnt_d = ms_cnt_q + DUR_W'(1);
            end else begin
               ms_cnt_d = ms_cnt_q;
            end
         end
         GAP: begin
            if (tick_s && (ms_cnt_q == GAP_LAST)) begin
               state_d  = IDLE;
               ms_cnt_d = '0;
            end else if (tick_s) begin
               ms_cnt_d = ms_cnt_q + DUR_W'(1);
            end else begin
               ms_cnt_d = ms_cnt_q;
            end
         end
         default: begin
            state_d  = IDLE;
            grant_d  = '0;
            pwm_en_d = 1'b0;
            period_d = '0;
            duty_d   = '0;
            ms_cnt_d = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
         pwm_en_q <= 1'b0;
         period_q <= '0;
         duty_q   <= '0;
         dur_q    <= '0;
         ms_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         pwm_en_q <= pwm_en_d;
         period_q <= period_d;
         duty_q   <= duty_d;
         dur_q    <= dur_d;
         ms_cnt_q <= ms_cnt_d;
      end
   end

   assign grant      = grant_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign pwm_en     = pwm_en_q;
   assign pwm_period = period_q;
   assign pwm_duty   = duty_q;

endmodule

// File: tb/tb_buzzer_tone_sched.sv
// Bench for buzzer_tone_sched: directed scenarios then random traffic, every
// cycle compared against a timeline model of grants, tone lengths and gaps.
module tb_buzzer_tone_sched;

   localparam int CLK_FREQ = 10_000;
   localparam int NUM_REQ  = 3;
   localparam int PERIOD_W = 24;
   localparam int DUR_W    = 16;
   localparam int GAP_MS   = 2;
   localparam int MS       = CLK_FREQ / 1000;
   localparam int GAP_CYC  = GAP_MS * MS;

   logic                         clk;
   logic                         rst;
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*PERIOD_W-1:0]  req_period;
   logic [NUM_REQ*DUR_W-1:0]     req_dur_ms;
   logic [NUM_REQ-1:0]           grant;
   logic [NUM_REQ-1:0]           done;
   logic                         busy;
   logic [PERIOD_W-1:0]          pwm_period;
   logic [PERIOD_W-1:0]          pwm_duty;
   logic                         pwm_en;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: tone timeline measured in clock cycles.
   bit            m_active;
   int            m_idx;
   int            m_len;
   int            m_elapsed;
   int            m_gap_left;
   logic [23:0]   m_per;
   bit            m_en;
   logic [2:0]    m_done;

   int  g_cnt [NUM_REQ];
   int  d_cnt [NUM_REQ];
   int  en_cnt;
   bit  pend [NUM_REQ];
   bit  rand_phase;

   buzzer_tone_sched #(
      .CLK_FREQ (CLK_FREQ),
      .NUM_REQ  (NUM_REQ),
      .PERIOD_W (PERIOD_W),
      .DUR_W    (DUR_W),
      .GAP_MS   (GAP_MS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_period (req_period),
      .req_dur_ms (req_dur_ms),
      .grant      (grant),
      .done       (done),
      .busy       (busy),
      .pwm_period (pwm_period),
      .pwm_duty   (pwm_duty),
      .pwm_en     (pwm_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [2:0] nd;
      int d;
      nd = 3'b000;
      if (rst) begin
         m_active   = 1'b0;
         m_gap_left = 0;
         m_done     = 3'b000;
         return;
      end
      if (m_active) begin
         if (m_elapsed + 1 == m_len) begin
            m_active   = 1'b0;
            nd[m_idx]  = 1'b1;
            m_gap_left = GAP_CYC;
         end
`ifdef BUZZER_TONE_PREEMPT_EN
         else if ((req & ((3'b001 << m_idx) - 3'b001)) != 3'b000) begin
            m_active   = 1'b0;
            nd[m_idx]  = 1'b1;
            m_gap_left = 0;
         end
`endif
         else begin
            m_elapsed++;
         end
      end else if (m_gap_left > 0) begin
         m_gap_left--;
      end else if ((req != 3'b000) && (m_done == 3'b000)) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) m_idx = i;
         end
         m_active  = 1'b1;
         m_elapsed = 0;
         m_per     = req_period[m_idx*PERIOD_W +: PERIOD_W];
         d         = int'(req_dur_ms[m_idx*DUR_W +: DUR_W]);
         m_len     = (d == 0) ? 1 : d * MS;
         m_en      = (m_per != 24'd0) && (d != 0);
      end
      m_done = nd;
   endtask

   task automatic step();
      logic [2:0]  exp_grant;
      logic [23:0] exp_per;
      model_edge();
      @(posedge clk);
      #1;
      exp_grant = m_active ? (3'b001 << m_idx) : 3'b000;
      exp_per   = m_active ? m_per : 24'd0;
      check("grant",      32'(grant),      32'(exp_grant));
      check("done",       32'(done),       32'(m_done));
      check("busy",       32'(busy),       32'(m_active || (m_gap_left > 0)));
      check("pwm_en",     32'(pwm_en),     32'(m_active && m_en));
      check("pwm_period", 32'(pwm_period), 32'(exp_per));
      check("pwm_duty",   32'(pwm_duty),   32'(exp_per >> 1));
      for (int i = 0; i < NUM_REQ; i++) begin
         g_cnt[i] += int'(grant[i]);
         d_cnt[i] += int'(done[i]);
         // A requester drops req on the edge after its done, unless it re-requests.
         if (pend[i]) begin
            if (!rand_phase || ($urandom_range(3) != 0)) req[i] = 1'b0;
            pend[i] = 1'b0;
         end
         if (m_done[i]) pend[i] = 1'b1;
      end
      en_cnt += int'(pwm_en);
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic clear_counts();
      for (int i = 0; i < NUM_REQ; i++) begin
         g_cnt[i] = 0;
         d_cnt[i] = 0;
      end
      en_cnt = 0;
   endtask

   task automatic set_tone(input int i, input logic [23:0] per, input logic [15:0] dur);
      req_period[i*PERIOD_W +: PERIOD_W] = per;
      req_dur_ms[i*DUR_W +: DUR_W]       = dur;
   endtask

   initial begin
      rst        = 1'b1;
      req        = 3'b000;
      req_period = '0;
      req_dur_ms = '0;
      rand_phase = 1'b0;
      m_active   = 1'b0;
      m_gap_left = 0;
      m_done     = 3'b000;
      m_idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) pend[i] = 1'b0;
      clear_counts();
      steps(3);
      rst = 1'b0;
      steps(2);

      // Single tone.
      clear_counts();
      set_tone(1, 24'd100, 16'd3);
      req[1] = 1'b1;
      steps(60);
      check("t1_grant_len", 32'(g_cnt[1]), 32'd30);
      check("t1_en_len",    32'(en_cnt),   32'd30);
      check("t1_done_cnt",  32'(d_cnt[1]), 32'd1);

      // Simultaneous requests.
      clear_counts();
      set_tone(1, 24'd300, 16'd1);
      set_tone(2, 24'd401, 16'd1);
      req = 3'b110;
      steps(80);
      check("sim_g1_len", 32'(g_cnt[1]), 32'd10);
      check("sim_g2_len", 32'(g_cnt[2]), 32'd10);

      // Timed rest.
      clear_counts();
      set_tone(0, 24'd0, 16'd2);
      req[0] = 1'b1;
      steps(50);
      check("rest_len",  32'(g_cnt[0]), 32'd20);
      check("rest_en",   32'(en_cnt),   32'd0);

      // Zero duration.
      clear_counts();
      set_tone(2, 24'd500, 16'd0);
      req[2] = 1'b1;
      steps(30);
      check("zero_len",  32'(g_cnt[2]), 32'd1);
      check("zero_en",   32'(en_cnt),   32'd0);
      check("zero_done", 32'(d_cnt[2]), 32'd1);

      // Higher-priority request arriving mid-tone.
      clear_counts();
      set_tone(2, 24'd200, 16'd5);
      req[2] = 1'b1;
      steps(10);
      set_tone(0, 24'd100, 16'd1);
      req[0] = 1'b1;
      steps(120);
`ifdef BUZZER_TONE_PREEMPT_EN
      check("pre_g2_len", 32'(g_cnt[2]), 32'd10);
`else
      check("pre_g2_len", 32'(g_cnt[2]), 32'd50);
`endif
      check("pre_g0_len", 32'(g_cnt[0]), 32'd10);

      // Reset mid-tone, then the held request is granted again.
      clear_counts();
      set_tone(1, 24'd100, 16'd4);
      req[1] = 1'b1;
      steps(15);
      rst = 1'b1;
      step();
      check("rst_no_done", 32'(d_cnt[1]), 32'd0);
      rst = 1'b0;
      steps(80);
      check("rst_regrant_done", 32'(d_cnt[1]), 32'd1);

      // Random traffic, including input changes during tones and short resets.
      rand_phase = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(15) == 0) req[i] = ~req[i];
            if ($urandom_range(7) == 0) begin
               set_tone(i, ($urandom_range(3) == 0) ? 24'd0 : 24'($urandom()),
                        16'($urandom_range(4)));
            end
         end
         rst = ($urandom_range(299) == 0);
         step();
      end
      rst = 1'b0;
      step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
